// File: rtl/ternary_stream_loader_pkg.sv
// Shared types and helpers for the ternary stream loader and its sub-module.
package ternary_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  // Bytes needed to carry the packed 2-bit weight matrix.
  function automatic int unsigned wbytes(input int unsigned in_len, input int unsigned out_len);
    return (2 * in_len * out_len + 7) / 8;
  endfunction

endpackage

// File: rtl/ternary_stream_loader_if.sv
// Byte-wide valid/ready stream feeding the loader.
interface ternary_stream_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ternary_stream_loader_byte_pair_packer.sv
// Pairs consecutive activation bytes into {high, low}; strobes on the high byte.
module byte_pair_packer #(
  parameter int unsigned BitWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  we,
  input  logic [BitWidth-1:0]   data,
  output logic [2*BitWidth-1:0] pair,
  output logic                  strobe
);

  logic                phase;
  logic [BitWidth-1:0] hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hold  <= '0;
    end else if (clear) begin
      phase <= 1'b0;
    end else if (we) begin
      if (!phase) hold <= data;
      phase <= ~phase;
    end
  end

  assign pair   = {data, hold};
  assign strobe = we & phase;

endmodule

// File: rtl/ternary_stream_loader.sv
// Loads the packed ternary weight matrix from a byte stream, then issues activation pairs with row tags.
module ternary_stream_loader
  import ternary_pkg::*;
#(
  parameter int unsigned InLen    = 14,
  parameter int unsigned OutLen   = 7,
  parameter int unsigned BitWidth = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        start_load,
  ternary_stream_loader_if.slave      stream,
  output logic [2*InLen*OutLen-1:0]   W,
  output logic [BitWidth*2-1:0]       VecIn,
  output logic [2:0]                  row,
  output logic                        vec_valid,
  output logic                        w_ready,
  output logic                        frame_done
);

  localparam int unsigned WW     = 2 * InLen * OutLen;
  localparam int unsigned WBYTES = wbytes(InLen, OutLen);
  localparam int unsigned KW     = $clog2(WBYTES);
  localparam int unsigned ROWS   = InLen / 2;

  state_t                state;
  logic [KW-1:0]         k;
  logic [2:0]            row_cnt;
  logic                  vec_valid_q;
  logic                  frame_done_q;
  logic                  xfer;
  logic                  restart;
  logic                  load_we;
  logic                  last_byte;
  logic                  pack_we;
  logic                  pack_clear;
  logic [WW-1:0]         w_next;
  logic [2*BitWidth-1:0] pair;
  logic                  pair_strobe;

  assign stream.in_ready = en & (state != IDLE);
  assign xfer            = stream.in_valid & stream.in_ready;
  assign restart         = en & start_load;
  assign load_we         = xfer & ~restart & (state == LOAD_W);
  assign pack_we         = xfer & ~restart & (state == STREAM);
  assign last_byte       = (k == KW'(WBYTES - 1));
  assign pack_clear      = restart | (load_we & last_byte);

  // Each byte lane is clipped to the matrix width so the final partial byte drops its upper bits.
  for (genvar i = 0; i < WBYTES; i++) begin : g_wbyte
    localparam int unsigned BW = (WW - 8 * i < 8) ? (WW - 8 * i) : 8;
    assign w_next[8*i +: BW] = (load_we && k == KW'(i)) ? stream.in_data[BW-1:0] : W[8*i +: BW];
  end

  byte_pair_packer #(.BitWidth(BitWidth)) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (pack_clear),
    .we     (pack_we),
    .data   (stream.in_data),
    .pair   (pair),
    .strobe (pair_strobe)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      row_cnt      <= '0;
      W            <= '0;
      VecIn        <= '0;
      row          <= '0;
      w_ready      <= 1'b0;
      vec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      vec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      W            <= w_next;
      if (restart) begin
        state   <= LOAD_W;
        k       <= '0;
        w_ready <= 1'b0;
        row_cnt <= '0;
      end else if (en) begin
        case (state)
          IDLE: begin
          end
          LOAD_W: begin
            if (load_we) begin
              if (last_byte) begin
                state   <= STREAM;
                w_ready <= 1'b1;
                row_cnt <= '0;
                k       <= '0;
              end else begin
                k <= k + KW'(1);
              end
            end
          end
          STREAM: begin
            if (pair_strobe) begin
              VecIn        <= pair;
              row          <= row_cnt;
              vec_valid_q  <= 1'b1;
              frame_done_q <= (row_cnt == 3'(ROWS - 1));
              row_cnt      <= (row_cnt == 3'(ROWS - 1)) ? '0 : row_cnt + 3'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign vec_valid  = vec_valid_q & en;
  assign frame_done = frame_done_q & en;

endmodule

// File: tb/tb_ternary_stream_loader.sv
// Scoreboard bench for ternary_stream_loader: a spec-level model predicts weights, pairs and row tags.
module tb_ternary_stream_loader;
  import ternary_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  logic start_load = 1'b0;
  logic [195:0] W;
  logic [15:0]  VecIn;
  logic [2:0]   row;
  logic vec_valid, w_ready, frame_done;

  ternary_stream_loader_if sif ();

  ternary_stream_loader #(.InLen(14), .OutLen(7), .BitWidth(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .start_load (start_load),
    .stream     (sif.slave),
    .W          (W),
    .VecIn      (VecIn),
    .row        (row),
    .vec_valid  (vec_valid),
    .w_ready    (w_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] vec;
    logic [2:0]  r;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // model state (0 idle, 1 load, 2 stream)
  int           m_state;
  int           m_k;
  int           m_row;
  bit           m_phase;
  logic [7:0]   m_hold;
  logic [195:0] m_w;
  bit           m_wr;
  bit           m_pend;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_k = 0; m_row = 0; m_phase = 0; m_hold = '0;
    m_w = '0; m_wr = 0; m_pend = 0;
  endtask

  task automatic do_reset();
    sif.in_valid = 1'b0;
    start_load   = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_W", W, '0);
    check("rst_vec", VecIn, '0);
    check("rst_row", row, '0);
    check("rst_flags", {w_ready, vec_valid, frame_done, sif.in_ready}, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock: drive inputs, check in_ready, advance model at the edge, then check registered outputs.
  task automatic step(input bit v, input logic [7:0] d, input bit sl, input bit e);
    logic [199:0] pad;
    exp_t x;
    bit xfer;
    sif.in_valid = v;
    sif.in_data  = d;
    start_load   = sl;
    en           = e;
    #1;
    check("in_ready", sif.in_ready, (e && m_state != 0));
    @(posedge clk);
    m_pend = 0;
    if (e) begin
      xfer = v && (m_state != 0);
      if (sl) begin
        m_state = 1; m_k = 0; m_wr = 0; m_phase = 0; m_row = 0;
      end else if (m_state == 1 && xfer) begin
        pad = {4'b0, m_w};
        pad[m_k*8 +: 8] = d;
        m_w = pad[195:0];
        if (m_k == 24) begin
          m_state = 2; m_wr = 1; m_row = 0; m_phase = 0; m_k = 0;
        end else begin
          m_k++;
        end
      end else if (m_state == 2 && xfer) begin
        if (!m_phase) begin
          m_hold = d; m_phase = 1;
        end else begin
          x.vec = {d, m_hold};
          x.r   = 3'(m_row);
          x.fd  = (m_row == 6);
          sb.push_back(x);
          m_pend  = 1;
          m_row   = (m_row + 1) % 7;
          m_phase = 0;
        end
      end
    end
    #1;
    check("W", W, m_w);
    check("w_ready", w_ready, m_wr);
    check("vec_valid", vec_valid, m_pend && en);
    if (vec_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        x = sb.pop_front();
        check("VecIn", VecIn, x.vec);
        check("row", row, x.r);
        check("frame_done", frame_done, x.fd);
      end
    end else begin
      check("frame_done_idle", frame_done, 0);
    end
  endtask

  initial begin
    logic [7:0] w0;
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    model_reset();
    #1;
    do_reset();

    // reset in the middle of a weight load
    step(0, 8'h00, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 8'(i + 8'hA0), 0, 1);
    do_reset();

    // full weight load with bytes 0x01..0x19
    step(0, 8'h00, 1, 1);
    for (int i = 1; i <= 25; i++) step(1, 8'(i), 0, 1);
    check("w_byte0", W[7:0], 8'h01);
    check("w_byte23", W[191:184], 8'h18);
    check("w_tail", W[195:192], 4'h9);
    check("w_ready_set", w_ready, 1);
    check("w_trit0", W[1:0], TRIT_POS);

    // one frame at full rate, then the wrap to row 0
    for (int i = 1; i <= 14; i++) begin
      step(1, 8'(i * 16), 0, 1);
      if (i == 14) begin
        check("last_vec", VecIn, 16'hE0D0);
        check("last_row", row, 3'd6);
        check("last_fd", frame_done, 1);
      end
    end
    step(1, 8'h11, 0, 1);
    step(1, 8'h22, 0, 1);
    check("wrap_row", row, 3'd0);

    // gappy valid with enable held low between low and high byte
    step(0, 8'h00, 0, 1);
    step(1, 8'h33, 0, 1);
    step(0, 8'h00, 0, 1);
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 1, 0);
    step(1, 8'h99, 0, 0);
    step(0, 8'h00, 0, 1);
    step(1, 8'h44, 0, 1);
    check("gap_vec", VecIn, 16'h4433);
    check("gap_row", row, 3'd1);

    // lone low byte then reload; first pair must restart at row 0
    step(1, 8'h55, 0, 1);
    step(0, 8'h00, 1, 1);
    check("reload_wr", w_ready, 0);
    for (int i = 0; i < 25; i++) step(1, 8'(i * 3 + 7), 0, 1);
    step(1, 8'h66, 0, 1);
    step(1, 8'h67, 0, 1);
    check("reload_vec", VecIn, 16'h6766);
    check("reload_row", row, 3'd0);

    // start_load on the same edge as a transfer: byte ignored
    w0 = W[7:0];
    step(1, 8'hAA, 1, 1);
    check("ign_w0", W[7:0], w0);
    step(1, 8'h5C, 0, 1);
    check("ign_next", W[7:0], 8'h5C);
    for (int i = 1; i < 25; i++) step(1, 8'(i + 8'h40), 0, 1);
    step(1, 8'h01, 0, 1);
    step(1, 8'h02, 0, 1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ternary_stream_loader.md
# ternary_stream_loader

Upstream feeder for the ternary matrix-vector multiplier. Accepts a byte-wide stream over a valid/ready handshake, deserializes it into the packed 2-bit ternary weight matrix, then assembles activation bytes into `BitWidth*2`-bit input pairs tagged with a wrapping row index. Outputs connect directly to the multiplier's `W`, `VecIn`, `row` and `en` inputs.

## Interface

- `InLen`, 14, input vector length; rows per frame = `InLen/2`.
- `OutLen`, 7, output vector length.
- `BitWidth`, 8, activation width; must be 8 (one activation per byte).
- `clk`  in  1  rising-edge clock, the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all state.
- `start_load`  in  1  single-cycle pulse: begin (re)loading weights.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `W`  out  `2*InLen*OutLen`  packed ternary weights (01 = +1, 11 = −1, 00/10 = 0).
- `VecIn`  out  `BitWidth*2`  activation pair {high, low}.
- `row`  out  3  row index of the current `VecIn`.
- `vec_valid`  out  1  one-cycle pulse: new `VecIn`/`row` issued.
- `w_ready`  out  1  complete weight set loaded and stable.
- `frame_done`  out  1  one-cycle pulse coincident with the `vec_valid` for the last row.

## Operation

- Byte transfer: occurs when `en & in_valid & in_ready` are all high at a rising edge.
- States: IDLE, LOAD_W, STREAM.
- IDLE: `in_ready`=0. `start_load` → LOAD_W.
- LOAD_W:
  - `in_ready`=1; byte counter `k` runs 0..`WBYTES`−1, where `WBYTES`=ceil(2·InLen·OutLen/8) = 25 by default.
  - Byte `k` writes `W[8k +: 8]`. For the final byte, only bits below the `W` width are kept (default: `W[195:192]` ← `in_data[3:0]`); the rest are discarded.
  - After the final byte: → STREAM, `w_ready`←1, row counter←0, pair phase←low.
- STREAM:
  - `in_ready`=1; `W` is held constant.
  - Phase low: the byte is latched into a holding register, and the phase toggles to high.
  - Phase high: `VecIn`←{`in_data`, held}, `row`←row counter, `vec_valid` pulses.
  - The row counter increments mod `InLen/2` (0..6, then wraps to 0). `frame_done` pulses when the issued row is `InLen/2`−1.
- `start_load` in LOAD_W or STREAM:
  - → LOAD_W with `k`←0 and `w_ready`←0 on the same edge.
  - Any half-received pair is discarded; the row counter is cleared.
  - A byte transferred on that same edge is ignored.
  - `W` is not cleared; it is overwritten byte by byte.
- `en`=0:
  - `in_ready` is forced to 0 and no state, counter or output register changes.
  - `vec_valid` and `frame_done` are forced to 0.
  - A `start_load` asserted while `en`=0 is ignored.
- Reset (any time, including mid-load):
  - State IDLE; `W`, `VecIn`, `row` and all counters are 0.
  - `w_ready`, `vec_valid`, `frame_done` and `in_ready` are all 0.

## Timing

- `in_ready` is combinational from state and `en` only; it does not depend on `in_valid`.
- `W` bytes are visible 1 cycle after transfer. `w_ready` rises 1 cycle after the final weight byte.
- `vec_valid`, `VecIn`, `row`, `frame_done`: registered and visible 1 cycle after the high-byte transfer. `VecIn` and `row` hold until the next pair.
- Full-rate streaming gives one `vec_valid` every 2 cycles. Gaps in `in_valid` only stretch the timing; pair and row order are unchanged.
- Throughput: 25 cycles per weight load; 14 cycles per 7-row frame.

## Structure

- Shared package `ternary_pkg`:
  - state enum {IDLE, LOAD_W, STREAM}.
  - ternary codes `TRIT_POS`=2'b01, `TRIT_NEG`=2'b11, `TRIT_ZERO`=2'b00.
  - function computing `WBYTES` from `InLen`/`OutLen`.
- Natural sub-module: `byte_pair_packer`. It holds the phase bit and holding register, and emits the 16-bit pair plus a pair strobe. The top level owns the FSM, the weight shift-in and the row counter.

## Test plan

- Reset mid-LOAD_W after 10 bytes → all outputs 0, state IDLE. A following `start_load` plus 25 bytes loads `W` correctly.
- `start_load`, then bytes 0x01..0x19 → `W[7:0]`=0x01, `W[191:184]`=0x18, `W[195:192]`=0x9; `w_ready`=1 exactly 1 cycle after the 25th byte.
- STREAM with 14 bytes 0x10,0x20,…,0xE0 at full rate → 7 `vec_valid` pulses 2 cycles apart. First `VecIn`=0x2010 with `row`=0; last `VecIn`=0xE0D0 with `row`=6 and `frame_done`=1. The next pair gets `row`=0.
- `in_valid` toggling every other cycle, plus `en` low for 3 cycles between the low and high byte → pair still {high, low}; no pulses while `en`=0.
- `start_load` after a lone low byte in STREAM → `w_ready`=0 next cycle, partial byte dropped. After reload, the first pair reports `row`=0.
- `start_load` on the same edge as a transfer in STREAM → byte ignored, `k`=0, `W` unchanged until the next transferred byte.
